// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver: LSB-first deserializer, single-error corrector,
// valid/ready output and saturating status counters.
module hamming_serial_rx #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] frame_err_cnt
);

    localparam int unsigned CW_W   = 7;
    localparam int unsigned BCNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DECODE,
        OUT
    } state_t;

    state_t            state;
    logic [BCNT_W-1:0] bit_cnt;
    logic [CW_W-1:0]   sr;

    logic [2:0]        syn_c;
    logic [CW_W-1:0]   fixed_c;
    logic              accept_c;

    // Ready is a pure decode of the state register.
    assign in_ready = (state == IDLE) || (state == SHIFT);
    assign accept_c = in_valid && in_ready;

    // Syndrome and single-bit correction of the captured word.
    always_comb begin
        syn_c[0] = sr[0] ^ sr[2] ^ sr[4] ^ sr[6];
        syn_c[1] = sr[1] ^ sr[2] ^ sr[5] ^ sr[6];
        syn_c[2] = sr[3] ^ sr[4] ^ sr[5] ^ sr[6];
        fixed_c  = sr;
        for (int i = 0; i < int'(CW_W); i++) begin
            if (syn_c == 3'(i + 1)) begin
                fixed_c[i] = ~sr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            sr            <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_syndrome  <= '0;
            out_corrected <= 1'b0;
            corr_cnt      <= '0;
            frame_err_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c && in_sof) begin
                        sr[0]   <= in_bit;
                        bit_cnt <= BCNT_W'(1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept_c) begin
                        if (in_sof) begin
                            // New start-of-frame aborts the partial word.
                            if (frame_err_cnt != CNT_MAX) begin
                                frame_err_cnt <= frame_err_cnt + CNT_W'(1);
                            end
                            sr[0]   <= in_bit;
                            bit_cnt <= BCNT_W'(1);
                        end else begin
                            sr[bit_cnt] <= in_bit;
                            bit_cnt     <= bit_cnt + BCNT_W'(1);
                            if (bit_cnt == BCNT_W'(CW_W - 1)) begin
                                state <= DECODE;
                            end
                        end
                    end
                end
                DECODE: begin
                    out_data      <= {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
                    out_syndrome  <= syn_c;
                    out_corrected <= (syn_c != 3'd0);
                    out_valid     <= 1'b1;
                    if ((syn_c != 3'd0) && (corr_cnt != CNT_MAX)) begin
                        corr_cnt <= corr_cnt + CNT_W'(1);
                    end
                    bit_cnt <= '0;
                    state   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Scoreboard bench for hamming_serial_rx; a second instance with 2-bit
// counters shares the stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_hamming_serial_rx;

    logic clk = 1'b0;
    logic rst, in_bit, in_valid, in_sof, out_ready;

    logic       in_ready_a, out_valid_a, out_corrected_a;
    logic [3:0] out_data_a;
    logic [2:0] out_syndrome_a;
    logic [7:0] corr_cnt_a, frame_err_cnt_a;

    logic       in_ready_b, out_valid_b, out_corrected_b;
    logic [3:0] out_data_b;
    logic [2:0] out_syndrome_b;
    logic [1:0] corr_cnt_b, frame_err_cnt_b;

    hamming_serial_rx #(.CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_syndrome(out_syndrome_a),
        .out_corrected(out_corrected_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .corr_cnt(corr_cnt_a), .frame_err_cnt(frame_err_cnt_a)
    );

    hamming_serial_rx #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_syndrome(out_syndrome_b),
        .out_corrected(out_corrected_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .corr_cnt(corr_cnt_b), .frame_err_cnt(frame_err_cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] s;
        logic       c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_corr = 0, m_corr2 = 0, m_ferr = 0, m_ferr2 = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Output monitor: pops on the cycle whose rising edge completes the handshake.
    always @(negedge clk) begin
        if (!rst && out_valid_a) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid_a), 32'd0);
            end else if (out_ready) begin
                mon_e = sb.pop_front();
                check("out_data", 32'(out_data_a), 32'(mon_e.d));
                check("out_syndrome", 32'(out_syndrome_a), 32'(mon_e.s));
                check("out_corrected", 32'(out_corrected_a), 32'(mon_e.c));
                check("b_out_valid", 32'(out_valid_b), 32'd1);
                check("b_out_data", 32'(out_data_b), 32'(mon_e.d));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic sof);
        int   guard;
        logic ok;
        guard    = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = sof;
        do begin
            @(negedge clk);
            ok = in_ready_a;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 100);
        if (!ok) check("in_ready_timeout", 32'(in_ready_a), 32'd1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // pos = 0 for a clean word, else 1..7 flips Hamming position pos.
    task automatic send_word(input logic [3:0] d, input int pos, input bit gaps);
        logic [6:0] cw;
        exp_t       e;
        cw = encode(d);
        if (pos != 0) begin
            cw[pos-1] = ~cw[pos-1];
            if (m_corr < 255) m_corr++;
            if (m_corr2 < 3) m_corr2++;
        end
        e.d = d;
        e.s = 3'(pos);
        e.c = (pos != 0);
        sb.push_back(e);
        for (int i = 0; i < 7; i++) begin
            if (gaps) tick(int'($urandom_range(0, 3)));
            send_bit(cw[i], i == 0);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            tick(1);
            g++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        tick(1);
    endtask

    task automatic wait_valid();
        int g;
        g = 0;
        while (!out_valid_a && g < 50) begin
            tick(1);
            g++;
        end
        check("wait_out_valid", 32'(out_valid_a), 32'd1);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_corr_cnt"}, 32'(corr_cnt_a), 32'(m_corr));
        check({tag, "_ferr_cnt"}, 32'(frame_err_cnt_a), 32'(m_ferr));
        check({tag, "_b_corr_cnt"}, 32'(corr_cnt_b), 32'(m_corr2));
        check({tag, "_b_ferr_cnt"}, 32'(frame_err_cnt_b), 32'(m_ferr2));
    endtask

    task automatic zero_models();
        m_corr  = 0;
        m_corr2 = 0;
        m_ferr  = 0;
        m_ferr2 = 0;
    endtask

    initial begin
        logic [3:0] dvals [3];
        dvals[0] = 4'b1010;
        dvals[1] = 4'b0000;
        dvals[2] = 4'b1111;

        rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        tick(2);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_data", 32'(out_data_a), 32'd0);
        check("rst_out_syndrome", 32'(out_syndrome_a), 32'd0);
        check("rst_out_corrected", 32'(out_corrected_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check_counters("rst");
        rst = 1'b0;
        tick(1);

        // Clean word with latency check
        send_word(4'b1010, 0, 1'b0);
        check("lat_decode_cycle", 32'(out_valid_a), 32'd0);
        check("lat_decode_in_ready", 32'(in_ready_a), 32'd0);
        tick(1);
        check("lat_out_valid", 32'(out_valid_a), 32'd1);
        drain();
        check_counters("clean");

        // Every single-bit error position on three data words
        for (int k = 0; k < 3; k++) begin
            for (int p = 1; p <= 7; p++) begin
                send_word(dvals[k], p, 1'b0);
                drain();
            end
        end
        check_counters("single_err");

        // Backpressure: no bits consumed, outputs stable
        out_ready = 1'b0;
        send_word(4'b0101, 3, 1'b0);
        wait_valid();
        in_valid = 1'b1; in_sof = 1'b1; in_bit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready_a), 32'd0);
            check("bp_out_valid", 32'(out_valid_a), 32'd1);
            check("bp_out_data", 32'(out_data_a), 32'h5);
            check("bp_out_syndrome", 32'(out_syndrome_a), 32'd3);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; in_sof = 1'b0;
        out_ready = 1'b1;
        drain();
        send_word(4'b1100, 0, 1'b0);
        drain();
        check_counters("backpressure");

        // Aborted partial frame, then stray non-sof bits in IDLE
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        m_ferr++;
        m_ferr2++;
        send_word(4'b0110, 0, 1'b0);
        drain();
        check_counters("framing");
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        tick(12);
        check("idle_drop_in_ready", 32'(in_ready_a), 32'd1);
        check("idle_drop_no_out", 32'(out_valid_a), 32'd0);
        send_word(4'b1001, 2, 1'b0);
        drain();

        // Random gaps between bits
        for (int p = 0; p <= 7; p++) begin
            send_word(4'b1011, p, 1'b1);
            drain();
        end
        check_counters("gaps");

        // Reset mid-frame
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        zero_models();
        check("rst_mid_out_valid", 32'(out_valid_a), 32'd0);
        check_counters("rst_mid");

        // Reset while holding output
        out_ready = 1'b0;
        send_word(4'b0011, 5, 1'b0);
        wait_valid();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        sb.delete();
        zero_models();
        check("rst_out_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_in_ready", 32'(in_ready_a), 32'd1);
        check_counters("rst_out");
        out_ready = 1'b1;
        send_word(4'b1110, 6, 1'b0);
        drain();
        check_counters("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
